uart_rx_deframer: RTL and testbench

- Asynchronous serial receiver. Consumes the synchronized, debounced RX line from the team's sync/debounce stage and recovers start/data/parity/stop framing by mid-bit sampling.
- Delivers each good character over a valid/ready handshake, with one-cycle error pulses for framing, parity and overrun.
- Sits between the RX pad conditioning and the RX FIFO / register interface of the UART controller.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_bit_timer.sv | 35 +++
 rtl/uart_rx_deframer.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx_deframer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and helpers: parity selection, receiver FSM states and
// the clocks-per-bit derivation used by both the RX and TX datapaths.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_ODD,
    PAR_EVEN
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } rx_state_t;

  localparam int MIN_CPB = 8;

  // Callers must reject results below MIN_CPB at elaboration.
  function automatic int calc_cpb(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Modulo-CPB bit timer: sample_tick_o fires on the last count of a half or full bit,
// combinationally from the count register; the counter wraps on every tick and on clear.
module uart_bit_timer #(
  parameter int CPB = 50
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic half_i,
  output logic sample_tick_o
);

  localparam int TW = $clog2(CPB);
  localparam logic [TW-1:0] FULL_LAST = TW'(CPB - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CPB / 2 - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    sample_tick_o = (cnt_q == (half_i ? HALF_LAST : FULL_LAST));
    cnt_d         = cnt_q + TW'(1);
    if (clr_i || sample_tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_deframer.sv
// Mid-bit sampling UART receiver; results register one cycle after the final stop sample.
// Output is valid/ready; a good character arriving while the output is still full is dropped and flagged as overrun.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int      CLK_FREQ_HZ = 50_000_000,
  parameter int      BAUD_RATE   = 1_000_000,
  parameter int      DATA_BITS   = 8,
  parameter parity_t PARITY      = PAR_NONE,
  parameter int      STOP_BITS   = 1
) (
  input  logic                 dest_clk_i,
  input  logic                 dest_rst_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 data_valid_o,
  input  logic                 data_ready_i,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int CPB = calc_cpb(CLK_FREQ_HZ, BAUD_RATE);
  localparam int BW  = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  if (CPB < MIN_CPB) begin : g_bad_cpb
    $error("uart_rx_deframer: clocks per bit must be at least 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_deframer: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_rx_deframer: STOP_BITS must be 1 or 2");
  end

  rx_state_t            state_q, state_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic                 stop_bad_q, stop_bad_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;
  logic                 timer_clr;
  logic                 tick;
  logic                 stop_low;

  uart_bit_timer #(
    .CPB(CPB)
  ) u_bit_timer (
    .clk_i        (dest_clk_i),
    .rst_i        (dest_rst_i),
    .clr_i        (timer_clr),
    .half_i       (state_q == START),
    .sample_tick_o(tick)
  );

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_bad_d    = par_bad_q;
    stop_bad_d   = stop_bad_q;
    data_d       = data_q;
    valid_d      = valid_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    overrun_d    = 1'b0;
    timer_clr    = 1'b0;
    stop_low     = stop_bad_q | ~rx_i;

    if (valid_q && data_ready_i) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        timer_clr = 1'b1;
        if (!rx_i) begin
          state_d    = START;
          bit_cnt_d  = '0;
          par_bad_d  = 1'b0;
          stop_bad_d = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_d   = rx_i ? IDLE : DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = {rx_i, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      uart_pkg::PARITY: begin
        if (tick) begin
          // Even parity expects the bit to equal the data XOR; odd expects its inverse.
          par_bad_d = (PARITY == PAR_EVEN) ? ((^shift_q) != rx_i) : ((^shift_q) == rx_i);
          state_d   = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (bit_cnt_q == LAST_STOP) begin
            bit_cnt_d = '0;
            if (stop_low) begin
              frame_err_d = 1'b1;
              state_d     = BREAK_WAIT;
            end else if (par_bad_q) begin
              parity_err_d = 1'b1;
              state_d      = IDLE;
            end else begin
              state_d = IDLE;
              if (!valid_q || data_ready_i) begin
                data_d  = shift_q;
                valid_d = 1'b1;
              end else begin
                overrun_d = 1'b1;
              end
            end
          end else begin
            bit_cnt_d  = bit_cnt_q + BW'(1);
            stop_bad_d = stop_low;
          end
        end
      end
      BREAK_WAIT: begin
        // A line held low must return high before another start can be taken.
        timer_clr = 1'b1;
        if (rx_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge dest_clk_i) begin
    if (dest_rst_i) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      stop_bad_q   <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      stop_bad_q   <= stop_bad_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = valid_q;
  assign frame_err_o  = frame_err_q;
  assign parity_err_o = parity_err_q;
  assign overrun_o    = overrun_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: an 8N1 and an 8E1 instance at 50 clocks per bit,
// per-edge stimulus tables and per-edge output logs checked against hand-computed edges.
module tb_uart_rx_deframer;

  localparam int CPB  = 50;
  localparam int LOGN = 3000;

  logic       clk = 1'b0;
  logic       rst;
  logic       rdy;
  logic       rx_n, rx_e;
  logic [7:0] dout_n, dout_e;
  logic       dv_n, fe_n, pe_n, ov_n, busy_n;
  logic       dv_e, fe_e, pe_e, ov_e, busy_e;

  int checks = 0;
  int errors = 0;

  logic       rx_pat  [0:LOGN-1];
  logic       rdy_pat [0:LOGN-1];
  logic       rst_pat [0:LOGN-1];
  logic [7:0] data_log[0:LOGN-1];
  logic       dv_log  [0:LOGN-1];
  logic       fe_log  [0:LOGN-1];
  logic       pe_log  [0:LOGN-1];
  logic       ov_log  [0:LOGN-1];
  logic       busy_log[0:LOGN-1];

  always #5 clk = ~clk;

  uart_rx_deframer #(
    .CLK_FREQ_HZ(50_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(8),
    .PARITY(uart_pkg::PAR_NONE), .STOP_BITS(1)
  ) dut (
    .dest_clk_i(clk), .dest_rst_i(rst), .rx_i(rx_n), .data_o(dout_n),
    .data_valid_o(dv_n), .data_ready_i(rdy), .frame_err_o(fe_n),
    .parity_err_o(pe_n), .overrun_o(ov_n), .busy_o(busy_n)
  );

  uart_rx_deframer #(
    .CLK_FREQ_HZ(50_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(8),
    .PARITY(uart_pkg::PAR_EVEN), .STOP_BITS(1)
  ) dut_e (
    .dest_clk_i(clk), .dest_rst_i(rst), .rx_i(rx_e), .data_o(dout_e),
    .data_valid_o(dv_e), .data_ready_i(rdy), .frame_err_o(fe_e),
    .parity_err_o(pe_e), .overrun_o(ov_e), .busy_o(busy_e)
  );

  // bit 0 is the start bit, then data LSB first, then parity/stop
  function automatic logic [15:0] mk8(input logic [7:0] d, input logic stop);
    return {7'b0, stop, d, 1'b0};
  endfunction

  function automatic logic [15:0] mk8p(input logic [7:0] d, input logic p);
    return {5'b0, 1'b1, p, d, 1'b0};
  endfunction

  task automatic clear_pats(input logic rdy_def);
    for (int e = 0; e < LOGN; e++) begin
      rx_pat[e]  = 1'b1;
      rdy_pat[e] = rdy_def;
      rst_pat[e] = 1'b0;
    end
  endtask

  task automatic put_frame(input int start, input logic [15:0] bits, input int nbits);
    for (int b = 0; b < nbits; b++)
      for (int c = 0; c < CPB; c++)
        rx_pat[start + b*CPB + c] = bits[b];
  endtask

  // Applies pattern entry e before edge e and logs the outputs seen after edge e.
  task automatic run_edges(input int n, input bit sel_e);
    for (int e = 0; e < n; e++) begin
      if (sel_e) rx_e = rx_pat[e]; else rx_n = rx_pat[e];
      rdy = rdy_pat[e];
      rst = rst_pat[e];
      @(posedge clk);
      @(negedge clk);
      data_log[e] = sel_e ? dout_e : dout_n;
      dv_log[e]   = sel_e ? dv_e   : dv_n;
      fe_log[e]   = sel_e ? fe_e   : fe_n;
      pe_log[e]   = sel_e ? pe_e   : pe_n;
      ov_log[e]   = sel_e ? ov_e   : ov_n;
      busy_log[e] = sel_e ? busy_e : busy_n;
    end
    rx_n = 1'b1;
    rx_e = 1'b1;
    rdy  = 1'b0;
    rst  = 1'b0;
  endtask

  task automatic test_reset;
    rst  = 1'b1;
    rx_n = 1'b1;
    rx_e = 1'b1;
    rdy  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({dout_n, dv_n, fe_n, pe_n, ov_n, busy_n} !== 13'h0) begin
      errors++;
      $display("FAIL reset_8n1 got %h required 0", {dout_n, dv_n, fe_n, pe_n, ov_n, busy_n});
    end
    checks++;
    if ({dout_e, dv_e, fe_e, pe_e, ov_e, busy_e} !== 13'h0) begin
      errors++;
      $display("FAIL reset_8e1 got %h required 0", {dout_e, dv_e, fe_e, pe_e, ov_e, busy_e});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    int pulses;
    clear_pats(1'b1);
    put_frame(0, mk8(8'hA5, 1'b1), 10);
    run_edges(520, 1'b0);
    checks++;
    if (dv_log[474] !== 1'b0) begin
      errors++; $display("FAIL basic_early_valid got %b required 0", dv_log[474]);
    end
    checks++;
    if ({dv_log[475], data_log[475]} !== {1'b1, 8'hA5}) begin
      errors++; $display("FAIL basic_char got v=%b d=%h required v=1 d=a5", dv_log[475], data_log[475]);
    end
    checks++;
    if (dv_log[476] !== 1'b0) begin
      errors++; $display("FAIL basic_accept got %b required 0", dv_log[476]);
    end
    checks++;
    if ({busy_log[474], busy_log[475]} !== 2'b10) begin
      errors++; $display("FAIL basic_busy_fall got %b required 10", {busy_log[474], busy_log[475]});
    end
    pulses = 0;
    for (int e = 0; e < 520; e++) pulses += int'(fe_log[e] | pe_log[e] | ov_log[e]);
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL basic_no_err got %0d pulses required 0", pulses);
    end
  endtask

  task automatic test_false_start;
    int pulses;
    clear_pats(1'b0);
    for (int e = 0; e < 20; e++) rx_pat[e] = 1'b0;
    run_edges(80, 1'b0);
    checks++;
    if ({busy_log[0], busy_log[24], busy_log[25]} !== 3'b110) begin
      errors++;
      $display("FAIL false_start_busy got %b required 110", {busy_log[0], busy_log[24], busy_log[25]});
    end
    pulses = 0;
    for (int e = 0; e < 80; e++) pulses += int'(fe_log[e] | pe_log[e] | ov_log[e] | dv_log[e]);
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL false_start_quiet got %0d events required 0", pulses);
    end
  endtask

  task automatic test_parity;
    clear_pats(1'b1);
    put_frame(0, mk8p(8'h5A, 1'b0), 11);
    run_edges(560, 1'b1);
    checks++;
    if ({dv_log[525], data_log[525], pe_log[525]} !== {1'b1, 8'h5A, 1'b0}) begin
      errors++;
      $display("FAIL parity_good got v=%b d=%h pe=%b required v=1 d=5a pe=0", dv_log[525], data_log[525], pe_log[525]);
    end
    clear_pats(1'b0);
    put_frame(0, mk8p(8'h03, 1'b1), 11);
    run_edges(560, 1'b1);
    checks++;
    if ({pe_log[524], pe_log[525], pe_log[526]} !== 3'b010) begin
      errors++;
      $display("FAIL parity_pulse got %b required 010", {pe_log[524], pe_log[525], pe_log[526]});
    end
    checks++;
    if ({dv_log[525], data_log[525]} !== {1'b0, 8'h5A}) begin
      errors++;
      $display("FAIL parity_hold got v=%b d=%h required v=0 d=5a", dv_log[525], data_log[525]);
    end
  endtask

  task automatic test_break;
    int pulses;
    int valids;
    clear_pats(1'b1);
    put_frame(0, mk8(8'h55, 1'b0), 10);
    for (int e = 500; e < 2500; e++) rx_pat[e] = 1'b0;
    run_edges(2560, 1'b0);
    pulses = 0;
    valids = 0;
    for (int e = 0; e < 2560; e++) begin
      pulses += int'(fe_log[e]);
      valids += int'(dv_log[e]);
    end
    checks++;
    if (fe_log[475] !== 1'b1 || pulses != 1) begin
      errors++; $display("FAIL break_frame_err got fe475=%b count=%0d required 1 and 1", fe_log[475], pulses);
    end
    checks++;
    if (valids != 0) begin
      errors++; $display("FAIL break_no_valid got %0d valid cycles required 0", valids);
    end
    checks++;
    if ({busy_log[1500], busy_log[2499], busy_log[2500]} !== 3'b110) begin
      errors++;
      $display("FAIL break_wait_busy got %b required 110", {busy_log[1500], busy_log[2499], busy_log[2500]});
    end
    clear_pats(1'b0);
    put_frame(0, mk8(8'h12, 1'b1), 10);
    run_edges(520, 1'b0);
    checks++;
    if ({dv_log[475], data_log[475]} !== {1'b1, 8'h12}) begin
      errors++; $display("FAIL break_recover got v=%b d=%h required v=1 d=12", dv_log[475], data_log[475]);
    end
  endtask

  task automatic test_back_to_back;
    int ovs;
    clear_pats(1'b0);
    rdy_pat[0] = 1'b1;
    run_edges(2, 1'b0);
    clear_pats(1'b0);
    put_frame(0, mk8(8'h11, 1'b1), 10);
    put_frame(500, mk8(8'h22, 1'b1), 10);
    run_edges(1000, 1'b0);
    ovs = 0;
    for (int e = 0; e < 1000; e++) ovs += int'(ov_log[e]);
    checks++;
    if ({dv_log[475], data_log[475]} !== {1'b1, 8'h11}) begin
      errors++; $display("FAIL b2b_first got v=%b d=%h required v=1 d=11", dv_log[475], data_log[475]);
    end
    checks++;
    if ({ov_log[974], ov_log[975], ov_log[976]} !== 3'b010 || ovs != 1) begin
      errors++;
      $display("FAIL overrun_pulse got %b count=%0d required 010 and 1", {ov_log[974], ov_log[975], ov_log[976]}, ovs);
    end
    checks++;
    if ({dv_log[976], data_log[976]} !== {1'b1, 8'h11}) begin
      errors++; $display("FAIL overrun_hold got v=%b d=%h required v=1 d=11", dv_log[976], data_log[976]);
    end
    clear_pats(1'b0);
    rdy_pat[0] = 1'b1;
    run_edges(2, 1'b0);
    clear_pats(1'b0);
    put_frame(0, mk8(8'h11, 1'b1), 10);
    put_frame(500, mk8(8'h22, 1'b1), 10);
    rdy_pat[975] = 1'b1;
    run_edges(1000, 1'b0);
    ovs = 0;
    for (int e = 0; e < 1000; e++) ovs += int'(ov_log[e]);
    checks++;
    if (data_log[974] !== 8'h11) begin
      errors++; $display("FAIL b2b_hold_before got d=%h required 11", data_log[974]);
    end
    checks++;
    if ({dv_log[975], data_log[975], dv_log[976]} !== {1'b1, 8'h22, 1'b1} || ovs != 0) begin
      errors++;
      $display("FAIL b2b_accept_same_edge got v=%b d=%h v+1=%b ov=%0d required 1 22 1 0",
               dv_log[975], data_log[975], dv_log[976], ovs);
    end
  endtask

  task automatic test_reset_mid;
    int pulses;
    clear_pats(1'b0);
    put_frame(0, mk8(8'h7E, 1'b1), 5);
    rst_pat[200] = 1'b1;
    run_edges(300, 1'b0);
    checks++;
    if ({busy_log[199], dv_log[199], data_log[199]} !== {1'b1, 1'b1, 8'h22}) begin
      errors++;
      $display("FAIL rst_mid_before got busy=%b v=%b d=%h required 1 1 22", busy_log[199], dv_log[199], data_log[199]);
    end
    checks++;
    if ({data_log[200], dv_log[200], fe_log[200], pe_log[200], ov_log[200], busy_log[200]} !== 13'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs got %h required 0",
               {data_log[200], dv_log[200], fe_log[200], pe_log[200], ov_log[200], busy_log[200]});
    end
    pulses = 0;
    for (int e = 200; e < 300; e++) pulses += int'(fe_log[e] | pe_log[e] | ov_log[e] | dv_log[e] | busy_log[e]);
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL rst_mid_quiet got %0d events required 0", pulses);
    end
    clear_pats(1'b1);
    put_frame(0, mk8(8'h81, 1'b1), 10);
    run_edges(520, 1'b0);
    checks++;
    if ({dv_log[475], data_log[475]} !== {1'b1, 8'h81}) begin
      errors++; $display("FAIL rst_mid_recover got v=%b d=%h required v=1 d=81", dv_log[475], data_log[475]);
    end
  endtask

  initial begin
    rst  = 1'b1;
    rdy  = 1'b0;
    rx_n = 1'b1;
    rx_e = 1'b1;
    test_reset();
    test_basic();
    test_false_start();
    test_parity();
    test_break();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
